seg7_scan_ctrl: RTL
===================

Name: seg7_scan_ctrl

Overview:
Self-scanning, parametrised multiplexed 7-segment display controller. It owns the refresh clock divider and the digit scan counter, double-buffers the display value so digits never tear mid-frame, and supports per-digit enable and decimal points. It sits between the CPU's display register and the board's segment/anode pins.

Parameters:
NUM_DIGITS, 6, number of digits scanned (legal 1..8).
CLK_DIV, 50000, clk cycles each digit is held (legal >= 2).
SEG_ACTIVE_LOW, 0, 1 inverts all SEGMENT bits at the output register.
AN_ACTIVE_LOW, 0, 1 inverts all AN bits at the output register.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
disp_num  input  4*NUM_DIGITS  hex value to show; nibble i drives digit i (digit 0 = bits 3:0).
dp_in  input  NUM_DIGITS  decimal point request per digit.
digit_en  input  NUM_DIGITS  per-digit enable; 0 = digit dark.
load  input  1  1-cycle strobe; captures disp_num and dp_in.
SEGMENT  output  8  bit7 = dp, bits 6:0 = g..a; registered.
AN  output  NUM_DIGITS  one-hot digit select; registered.
frame_done  output  1  1-cycle pulse at each frame wrap.

Behaviour:
- Reset (rst high at a clk edge): div_cnt=0, idx=0, pending=0, pend_num/pend_dp=0, shadow_num/shadow_dp=0, frame_done=0. AN is all-inactive (0, or all-1 if AN_ACTIVE_LOW). SEGMENT is all-off (8'h00, or 8'hFF if SEG_ACTIVE_LOW). Reset mid-frame aborts the scan, drops any pending load, and applies the same values.
- Divider: div_cnt counts 0..CLK_DIV-1. At CLK_DIV-1 it returns to 0 and idx advances ("tick"). idx wraps NUM_DIGITS-1 -> 0.
- frame_done is high for exactly the cycle after the tick that wraps idx to 0.
- Load handshake (no back-pressure):
  - A load with no wrap tick in the same cycle writes pend_num/pend_dp and sets pending.
  - A second load before the wrap overwrites pend_* (last wins).
  - On a wrap tick with pending=1, shadow <= pend_* and pending clears.
  - A load in the same cycle as a wrap tick writes disp_num/dp_in directly into shadow, and pending clears.
  - The shadow never changes at any other time.
- Output stage, every cycle from the current idx and shadow:
  - AN: one-hot bit idx, or all-inactive if digit_en[idx]=0.
  - SEGMENT[6:0]: hex table 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71.
  - SEGMENT[7] = shadow_dp[idx].
  - Disabled digit: SEGMENT all-off.
  - Polarity inversion is applied last.
- Latency: AN/SEGMENT reflect a new idx 1 cycle after the tick. They reflect a new shadow 1 cycle after the shadow update. The first AN (digit 0) is valid on the 1st cycle after rst deasserts.
- digit_en is not buffered; it takes effect with the 1-cycle output latency.
- NUM_DIGITS=1: idx is constant 0 and every tick is a wrap (frame_done every CLK_DIV cycles).

Optional Feature:
Macro LZ_SUPPRESS_EN.
- Defined: leading-zero suppression. Digit i>0 is blanked (AN inactive, SEGMENT off, dp forced off) when shadow nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is always shown if enabled. The mask is derived combinationally from the shadow, so it changes only at frame boundaries.
- Undefined: every enabled digit shows its nibble, including leading zeros. No suppression logic is synthesised.

Test Plan:
1. NUM_DIGITS=6, CLK_DIV=4, rst then load disp_num=24'h12AB9F, digit_en=6'h3F -> over the frame, AN walks 000001..100000, each held 4 cycles. SEGMENT sequence is 71,6F,7C,77,5B,06. frame_done pulses once per 24 cycles.
2. Load 24'h000000 mid-frame while digit 3 is showing -> digits 3..5 still show the old value. The new value appears from digit 0 of the next frame, 1 cycle after frame_done.
3. Assert load exactly on the wrap tick with 24'h0000F0 -> the first digit of the new frame already uses the new value. pending reads 0 afterwards.
4. digit_en=6'b111110, dp_in=6'b000010 -> during slot 0, AN=0 and SEGMENT=00. During slot 1, SEGMENT bit7=1.
5. With LZ_SUPPRESS_EN, disp_num=24'h000305 -> digits 5,4,3 are dark, digits 2..0 show 4F,3F,6D. Loading 0 shows only digit 0 = 3F.
6. SEG_ACTIVE_LOW=1, AN_ACTIVE_LOW=1, rst held 3 cycles mid-frame -> AN=6'h3F and SEGMENT=8'hFF during reset. Scan restarts at digit 0 with an all-zero shadow.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Self-scanning multiplexed 7-segment controller with a double-buffered display value.
// Optional leading-zero suppression is built only when LZ_SUPPRESS_EN is defined.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS     = 6,
    parameter int CLK_DIV        = 50000,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] disp_num,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    output logic [7:0]              SEGMENT,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic                    frame_done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [7:0]            SEG_INV  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] AN_INV   = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    logic [DIV_W-1:0]        r_divCnt;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_pending;
    logic [4*NUM_DIGITS-1:0] r_pendNum;
    logic [NUM_DIGITS-1:0]   r_pendDp;
    logic [4*NUM_DIGITS-1:0] r_shadowNum;
    logic [NUM_DIGITS-1:0]   r_shadowDp;

    logic                    w_tick;
    logic                    w_wrap;
    logic [NUM_DIGITS-1:0]   w_lzBlank;
    logic [3:0]              w_nib;
    logic                    w_dp;
    logic                    w_show;
    logic [NUM_DIGITS-1:0]   w_anOneHot;
    logic [7:0]              w_segRaw;
    logic [NUM_DIGITS-1:0]   w_anRaw;

    function automatic logic [6:0] hexToSeg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    assign w_tick = (r_divCnt == DIV_LAST);
    assign w_wrap = w_tick && (r_idx == IDX_LAST);

`ifdef LZ_SUPPRESS_EN
    // A digit above 0 is blank while it and every higher nibble are zero.
    always_comb begin
        logic w_upperZero;
        w_upperZero = 1'b1;
        w_lzBlank   = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            w_upperZero  = w_upperZero & (r_shadowNum[4*i +: 4] == 4'h0);
            w_lzBlank[i] = w_upperZero;
        end
    end
`else
    assign w_lzBlank = '0;
`endif

    always_comb begin
        w_nib      = 4'h0;
        w_dp       = 1'b0;
        w_show     = 1'b0;
        w_anOneHot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib         = r_shadowNum[4*i +: 4];
                w_dp          = r_shadowDp[i];
                w_show        = digit_en[i] & ~w_lzBlank[i];
                w_anOneHot[i] = 1'b1;
            end
        end
    end

    assign w_segRaw = w_show ? {w_dp, hexToSeg(w_nib)} : 8'h00;
    assign w_anRaw  = w_show ? w_anOneHot : '0;

    // Shadow only changes on a wrap tick, so a frame never mixes two values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_divCnt    <= '0;
            r_idx       <= '0;
            r_pending   <= 1'b0;
            r_pendNum   <= '0;
            r_pendDp    <= '0;
            r_shadowNum <= '0;
            r_shadowDp  <= '0;
            frame_done  <= 1'b0;
            SEGMENT     <= SEG_INV;
            AN          <= AN_INV;
        end else begin
            if (w_tick) begin
                r_divCnt <= '0;
                r_idx    <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_divCnt <= r_divCnt + 1'b1;
            end

            if (load && w_wrap) begin
                r_shadowNum <= disp_num;
                r_shadowDp  <= dp_in;
                r_pending   <= 1'b0;
            end else if (load) begin
                r_pendNum <= disp_num;
                r_pendDp  <= dp_in;
                r_pending <= 1'b1;
            end else if (w_wrap && r_pending) begin
                r_shadowNum <= r_pendNum;
                r_shadowDp  <= r_pendDp;
                r_pending   <= 1'b0;
            end

            frame_done <= w_wrap;
            SEGMENT    <= w_segRaw ^ SEG_INV;
            AN         <= w_anRaw ^ AN_INV;
        end
    end

endmodule
